// File: rtl/SubBytes.sv
// rtl/SubBytes.sv - combinational AES forward S-box, one byte in, one byte out
module SubBytes (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry i lives at bits [8*(255-i) +: 8], so the first-listed byte maps to input 00.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expansion.sv
// rtl/aes_key_expansion.sv - sequential AES-128 key schedule, one round key per clock
module aes_key_expansion (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            KE_START,
    input  logic [127:0]    KE_KEY,
    output logic            KE_BUSY,
    output logic            KE_DONE,
    output logic [1407:0]   ROUND_KEYS
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      rnd_q, rnd_d;
    logic [127:0]    w_q, w_d;
    logic [1407:0]   rk_q, rk_d;

    logic [31:0]     w0, w1, w2, w3;
    logic [31:0]     rot_w, sub_w, t;
    logic [31:0]     n0, n1, n2, n3;
    logic [7:0]      rcon;

    assign w0 = w_q[127:96];
    assign w1 = w_q[95:64];
    assign w2 = w_q[63:32];
    assign w3 = w_q[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        SubBytes u_sbox (
            .din  (rot_w[8*b +: 8]),
            .dout (sub_w[8*b +: 8])
        );
    end

    always_comb begin
        case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t  = sub_w ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        w_d     = w_q;
        rk_d    = rk_q;
        case (state_q)
            S_IDLE: begin
                if (KE_START) begin
                    w_d          = KE_KEY;
                    rk_d[127:0]  = KE_KEY;
                    rnd_d        = 4'd1;
                    state_d      = S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_d = {n0, n1, n2, n3};
                for (int s = 1; s <= 10; s++) begin
                    if (rnd_q == 4'(s))
                        rk_d[128*s +: 128] = {n0, n1, n2, n3};
                end
                if (rnd_q == 4'd10)
                    state_d = S_DONE;
                else
                    rnd_d = rnd_q + 4'd1;
            end
            S_DONE: begin
                if (!KE_START)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            w_q     <= '0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            w_q     <= w_d;
            rk_q    <= rk_d;
        end
    end

    assign KE_BUSY    = (state_q == S_EXPAND);
    assign KE_DONE    = (state_q == S_DONE);
    assign ROUND_KEYS = rk_q;

endmodule
